// File: rtl/axis_byte_serializer_pkg.sv
// rtl/axis_byte_serializer_pkg.sv - byte-lane constants and mask helpers for the beat-to-byte serializer
package axis_byte_serializer_pkg;

    localparam int LANE_WIDTH = 8;
    localparam int MAX_LANES  = 64;

    typedef logic [MAX_LANES-1:0] lane_mask_t;

    function automatic int lowest_set_index(input lane_mask_t mask);
        lowest_set_index = 0;
        for (int i = MAX_LANES - 1; i >= 0; i--) begin
            if (mask[i]) begin
                lowest_set_index = i;
            end
        end
    endfunction

    function automatic logic at_most_one_set(input lane_mask_t mask);
        return (mask & (mask - lane_mask_t'(1))) == '0;
    endfunction

endpackage

// File: rtl/axis_byte_serializer_lane_picker.sv
// rtl/axis_byte_serializer_lane_picker.sv - combinational lowest-lane selector for a byte keep mask
module axis_lane_picker
    import axis_byte_serializer_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic [LANES-1:0]         mask,
    output logic [$clog2(LANES)-1:0] index,
    output logic [LANES-1:0]         rest_mask,
    output logic                     is_last,
    output logic                     any
);

    always_comb begin
        index     = $clog2(LANES)'(lowest_set_index(lane_mask_t'(mask)));
        rest_mask = mask & (mask - LANES'(1));
        is_last   = (rest_mask == '0);
        any       = (mask != '0);
    end

endmodule

// File: rtl/axis_byte_serializer.sv
// rtl/axis_byte_serializer.sv - unpacks multi-byte stream beats into one byte per cycle with frame status
module axis_byte_serializer
    import axis_byte_serializer_pkg::*;
#(
    parameter int WIDTH_IN_BYTES = 4,
    parameter int TID_WIDTH      = 8,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                in_tvalid,
    output logic                                in_tready,
    input  logic [LANE_WIDTH*WIDTH_IN_BYTES-1:0] in_tdata,
    input  logic [WIDTH_IN_BYTES-1:0]           in_tkeep,
    input  logic                                in_tlast,
    input  logic [TID_WIDTH-1:0]                in_tid,
    output logic                                out_tvalid,
    input  logic                                out_tready,
    output logic [LANE_WIDTH-1:0]               out_tdata,
    output logic                                out_tlast,
    output logic [TID_WIDTH-1:0]                out_tid,
    output logic [COUNT_WIDTH-1:0]              byte_count,
    output logic [15:0]                         frame_count,
    output logic                                null_last
);

    localparam int DATA_W = LANE_WIDTH * WIDTH_IN_BYTES;
    localparam int IDX_W  = $clog2(WIDTH_IN_BYTES);

    logic                      out_tvalid_q, out_tvalid_d;
    logic [LANE_WIDTH-1:0]     out_tdata_q, out_tdata_d;
    logic                      out_tlast_q, out_tlast_d;
    logic [TID_WIDTH-1:0]      out_tid_q, out_tid_d;
    logic [DATA_W-1:0]         hold_data_q, hold_data_d;
    logic [WIDTH_IN_BYTES-1:0] hold_mask_q, hold_mask_d;
    logic                      hold_last_q, hold_last_d;
    logic [TID_WIDTH-1:0]      hold_tid_q, hold_tid_d;
    logic [COUNT_WIDTH-1:0]    byte_count_q, byte_count_d;
    logic [15:0]               frame_count_q, frame_count_d;
    logic                      null_last_q, null_last_d;

    logic [IDX_W-1:0]          hold_idx, in_idx;
    logic [WIDTH_IN_BYTES-1:0] hold_rest, in_rest;
    logic                      hold_is_last, in_is_last;
    logic                      hold_any, in_any;

    logic advance, accept, out_hs, hs_last, null_frame;

    axis_lane_picker #(.LANES(WIDTH_IN_BYTES)) u_hold_picker (
        .mask      (hold_mask_q),
        .index     (hold_idx),
        .rest_mask (hold_rest),
        .is_last   (hold_is_last),
        .any       (hold_any)
    );

    axis_lane_picker #(.LANES(WIDTH_IN_BYTES)) u_in_picker (
        .mask      (in_tkeep),
        .index     (in_idx),
        .rest_mask (in_rest),
        .is_last   (in_is_last),
        .any       (in_any)
    );

    // A new beat may enter while the last held byte leaves, keeping the output gapless.
    assign advance    = !out_tvalid_q || out_tready;
    assign in_tready  = advance && at_most_one_set(lane_mask_t'(hold_mask_q));
    assign accept     = in_tvalid && in_tready;
    assign out_hs     = out_tvalid_q && out_tready;
    assign hs_last    = out_hs && out_tlast_q;
    assign null_frame = accept && !in_any && in_tlast;

    always_comb begin
        out_tvalid_d  = out_tvalid_q;
        out_tdata_d   = out_tdata_q;
        out_tlast_d   = out_tlast_q;
        out_tid_d     = out_tid_q;
        hold_data_d   = hold_data_q;
        hold_mask_d   = hold_mask_q;
        hold_last_d   = hold_last_q;
        hold_tid_d    = hold_tid_q;
        byte_count_d  = byte_count_q;
        frame_count_d = frame_count_q;
        null_last_d   = null_last_q;

        if (advance) begin
            if (hold_any) begin
                out_tvalid_d = 1'b1;
                out_tdata_d  = hold_data_q[LANE_WIDTH*hold_idx +: LANE_WIDTH];
                out_tlast_d  = hold_last_q && hold_is_last;
                out_tid_d    = hold_tid_q;
                hold_mask_d  = hold_rest;
                if (accept && in_any) begin
                    hold_data_d = in_tdata;
                    hold_mask_d = in_tkeep;
                    hold_last_d = in_tlast;
                    hold_tid_d  = in_tid;
                end
            end else if (accept && in_any) begin
                out_tvalid_d = 1'b1;
                out_tdata_d  = in_tdata[LANE_WIDTH*in_idx +: LANE_WIDTH];
                out_tlast_d  = in_tlast && in_is_last;
                out_tid_d    = in_tid;
                hold_data_d  = in_tdata;
                hold_mask_d  = in_rest;
                hold_last_d  = in_tlast;
                hold_tid_d   = in_tid;
            end else begin
                out_tvalid_d = 1'b0;
            end
        end

        if (hs_last) begin
            byte_count_d = '0;
        end else if (out_hs && (byte_count_q != '1)) begin
            byte_count_d = byte_count_q + 1'b1;
        end

        // An empty tlast beat still closes the frame it belongs to.
        if (null_frame) begin
            null_last_d  = 1'b1;
            byte_count_d = '0;
        end
        frame_count_d = frame_count_q + {15'd0, hs_last} + {15'd0, null_frame};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_tvalid_q  <= 1'b0;
            out_tdata_q   <= '0;
            out_tlast_q   <= 1'b0;
            out_tid_q     <= '0;
            hold_data_q   <= '0;
            hold_mask_q   <= '0;
            hold_last_q   <= 1'b0;
            hold_tid_q    <= '0;
            byte_count_q  <= '0;
            frame_count_q <= '0;
            null_last_q   <= 1'b0;
        end else begin
            out_tvalid_q  <= out_tvalid_d;
            out_tdata_q   <= out_tdata_d;
            out_tlast_q   <= out_tlast_d;
            out_tid_q     <= out_tid_d;
            hold_data_q   <= hold_data_d;
            hold_mask_q   <= hold_mask_d;
            hold_last_q   <= hold_last_d;
            hold_tid_q    <= hold_tid_d;
            byte_count_q  <= byte_count_d;
            frame_count_q <= frame_count_d;
            null_last_q   <= null_last_d;
        end
    end

    assign out_tvalid  = out_tvalid_q;
    assign out_tdata   = out_tdata_q;
    assign out_tlast   = out_tlast_q;
    assign out_tid     = out_tid_q;
    assign byte_count  = byte_count_q;
    assign frame_count = frame_count_q;
    assign null_last   = null_last_q;

endmodule

// File: tb/tb_axis_byte_serializer.sv
// tb/tb_axis_byte_serializer.sv - self-checking bench for axis_byte_serializer
`timescale 1ns/1ps
module tb_axis_byte_serializer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_tvalid = 1'b0;
    logic        in_tready;
    logic [31:0] in_tdata = '0;
    logic [3:0]  in_tkeep = '0;
    logic        in_tlast = 1'b0;
    logic [7:0]  in_tid = '0;
    logic        out_tvalid;
    logic        out_tready = 1'b1;
    logic [7:0]  out_tdata;
    logic        out_tlast;
    logic [7:0]  out_tid;
    logic [15:0] byte_count;
    logic [15:0] frame_count;
    logic        null_last;

    always #5 clk = ~clk;

    axis_byte_serializer #(
        .WIDTH_IN_BYTES (4),
        .TID_WIDTH      (8),
        .COUNT_WIDTH    (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_tvalid   (in_tvalid),
        .in_tready   (in_tready),
        .in_tdata    (in_tdata),
        .in_tkeep    (in_tkeep),
        .in_tlast    (in_tlast),
        .in_tid      (in_tid),
        .out_tvalid  (out_tvalid),
        .out_tready  (out_tready),
        .out_tdata   (out_tdata),
        .out_tlast   (out_tlast),
        .out_tid     (out_tid),
        .byte_count  (byte_count),
        .frame_count (frame_count),
        .null_last   (null_last)
    );

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic [7:0] tid;
        int         cyc;
    } obs_t;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic [7:0] tid;
    } exp_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic [7:0]  tid;
        int          n;
        logic [31:0] exp_bytes;
        int          exp_bc;
        int          exp_fc;
        logic        exp_null;
    } vec_t;

    obs_t got[$];
    exp_t model_q[$];
    exp_t e;
    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    logic acc_now = 1'b0;
    int   m_bc = 0;
    int   m_fc = 0;
    logic m_null = 1'b0;
    int   hi;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic       prev_last;
    logic [7:0] prev_tid;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: every accepted beat contributes its kept bytes in ascending lane order.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            model_q.delete();
            m_bc = 0;
            m_fc = 0;
            m_null = 1'b0;
            prev_stall = 1'b0;
            acc_now = 1'b0;
        end else begin
            check("byte_count", byte_count, m_bc);
            check("frame_count", frame_count, m_fc);
            check("null_last", null_last, m_null);
            if (prev_stall) begin
                check("stall_valid", out_tvalid, 1);
                check("stall_data", out_tdata, prev_data);
                check("stall_last", out_tlast, prev_last);
                check("stall_tid", out_tid, prev_tid);
            end
            prev_stall = out_tvalid && !out_tready;
            prev_data = out_tdata;
            prev_last = out_tlast;
            prev_tid = out_tid;
            if (out_tvalid && out_tready) begin
                got.push_back('{data: out_tdata, last: out_tlast, tid: out_tid, cyc: cyc});
                if (model_q.size() == 0) begin
                    check("spurious_byte", out_tdata, 64'hFFFF_FFFF);
                end else begin
                    e = model_q.pop_front();
                    check("model_data", out_tdata, e.data);
                    check("model_last", out_tlast, e.last);
                    check("model_tid", out_tid, e.tid);
                    if (e.last) begin
                        m_bc = 0;
                        m_fc = (m_fc + 1) % 65536;
                    end else if (m_bc < 65535) begin
                        m_bc++;
                    end
                end
            end
            acc_now = in_tvalid && in_tready;
            if (acc_now) begin
                hi = -1;
                for (int i = 0; i < 4; i++) if (in_tkeep[i]) hi = i;
                for (int i = 0; i < 4; i++) begin
                    if (in_tkeep[i]) begin
                        model_q.push_back('{data: in_tdata[8*i +: 8], last: (in_tlast && i == hi), tid: in_tid});
                    end
                end
                if (in_tlast && hi < 0) begin
                    m_null = 1'b1;
                    m_fc = (m_fc + 1) % 65536;
                    m_bc = 0;
                end
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l,
                             input logic [7:0] t, output int waits);
        int   budget;
        logic ok;
        budget = 0;
        waits = 0;
        in_tvalid = 1'b1;
        in_tdata = d;
        in_tkeep = k;
        in_tlast = l;
        in_tid = t;
        forever begin
            @(negedge clk);
            ok = in_tready;
            if (!ok) waits++;
            @(posedge clk);
            #1;
            if (ok) break;
            budget++;
            if (budget > 50) begin
                check("send_timeout", 1, 0);
                break;
            end
        end
        in_tvalid = 1'b0;
    endtask

    vec_t vecs[5];
    int   w, w1, w2, w3;
    logic [31:0] bytes;
    logic [7:0]  pat;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h44332211, 4'b1111, 1'b1, 8'd5, 4, 32'h44332211, 0, 1, 1'b0};
        vecs[1] = '{32'hDDCCBBAA, 4'b1010, 1'b1, 8'd3, 2, 32'h0000DDBB, 0, 2, 1'b0};
        vecs[2] = '{32'h00000000, 4'b0000, 1'b1, 8'd7, 0, 32'h00000000, 0, 3, 1'b1};
        vecs[3] = '{32'h12345678, 4'b0100, 1'b0, 8'd9, 1, 32'h00000034, 1, 3, 1'b1};
        vecs[4] = '{32'hCAFEBABE, 4'b1001, 1'b1, 8'd2, 2, 32'h0000CABE, 0, 4, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_out_tvalid", out_tvalid, 0);
        check("rst_out_tdata", out_tdata, 0);
        check("rst_out_tlast", out_tlast, 0);
        check("rst_out_tid", out_tid, 0);
        check("rst_byte_count", byte_count, 0);
        check("rst_frame_count", frame_count, 0);
        check("rst_null_last", null_last, 0);
        check("rst_in_tready", in_tready, 1);

        for (int v = 0; v < 5; v++) begin
            got.delete();
            send_beat(vecs[v].data, vecs[v].keep, vecs[v].last, vecs[v].tid, w);
            wait_cycles(8);
            check($sformatf("vec%0d_count", v), got.size(), vecs[v].n);
            bytes = vecs[v].exp_bytes;
            for (int j = 0; j < vecs[v].n && j < got.size(); j++) begin
                check($sformatf("vec%0d_byte%0d", v, j), got[j].data, bytes[8*j +: 8]);
                check($sformatf("vec%0d_last%0d", v, j), got[j].last, vecs[v].last && (j == vecs[v].n - 1));
                check($sformatf("vec%0d_tid%0d", v, j), got[j].tid, vecs[v].tid);
            end
            check($sformatf("vec%0d_bc", v), byte_count, vecs[v].exp_bc);
            check($sformatf("vec%0d_fc", v), frame_count, vecs[v].exp_fc);
            check($sformatf("vec%0d_null", v), null_last, vecs[v].exp_null);
        end

        // Back-to-back beats must emit gaplessly.
        got.delete();
        send_beat(32'h04030201, 4'b1111, 1'b0, 8'd1, w);
        send_beat(32'h08070605, 4'b0011, 1'b1, 8'd1, w);
        wait_cycles(8);
        check("b2b_count", got.size(), 6);
        for (int j = 0; j < 6 && j < got.size(); j++) begin
            check($sformatf("b2b_byte%0d", j), got[j].data, j + 1);
            check($sformatf("b2b_last%0d", j), got[j].last, j == 5);
            check($sformatf("b2b_gap%0d", j), got[j].cyc - got[0].cyc, j);
        end

        // Steady-state acceptance: one beat every four cycles.
        got.delete();
        send_beat(32'h13121110, 4'b1111, 1'b0, 8'd2, w1);
        send_beat(32'h17161514, 4'b1111, 1'b0, 8'd2, w2);
        send_beat(32'h1B1A1918, 4'b1111, 1'b1, 8'd2, w3);
        wait_cycles(8);
        check("tready_first_wait", w1, 0);
        check("tready_steady_wait", w3, 3);
        check("steady_count", got.size(), 12);
        for (int j = 0; j < 12 && j < got.size(); j++) begin
            check($sformatf("steady_gap%0d", j), got[j].cyc - got[0].cyc, j);
        end

        // Output stalls mid-beat.
        got.delete();
        pat = 8'b1111_1001;
        send_beat(32'h44332211, 4'b1111, 1'b1, 8'd6, w);
        for (int j = 0; j < 8; j++) begin
            out_tready = pat[j];
            wait_cycles(1);
        end
        out_tready = 1'b1;
        wait_cycles(4);
        check("stall_count", got.size(), 4);
        for (int j = 0; j < 4 && j < got.size(); j++) begin
            check($sformatf("stall_byte%0d", j), got[j].data, 8'h11 * (j + 1));
            check($sformatf("stall_lastflag%0d", j), got[j].last, j == 3);
        end

        // Reset after two of four bytes.
        got.delete();
        send_beat(32'h44332211, 4'b1111, 1'b1, 8'd1, w);
        wait_cycles(2);
        reset = 1'b1;
        wait_cycles(1);
        reset = 1'b0;
        check("midrst_out_tvalid", out_tvalid, 0);
        check("midrst_byte_count", byte_count, 0);
        check("midrst_frame_count", frame_count, 0);
        check("midrst_null_last", null_last, 0);
        check("midrst_emitted", got.size(), 2);
        got.delete();
        send_beat(32'h88776655, 4'b1111, 1'b1, 8'd4, w);
        wait_cycles(8);
        check("postrst_count", got.size(), 4);
        for (int j = 0; j < 4 && j < got.size(); j++) begin
            check($sformatf("postrst_byte%0d", j), got[j].data, 8'h55 + 8'h11 * j);
        end

        // Randomized traffic against the reference model.
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            #1;
            reset = ($urandom_range(0, 999) == 0);
            out_tready = ($urandom_range(0, 3) != 0);
            if (!in_tvalid || acc_now) begin
                if ($urandom_range(0, 3) != 0) begin
                    in_tvalid = 1'b1;
                    in_tdata = $urandom;
                    in_tkeep = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom);
                    in_tlast = ($urandom_range(0, 2) == 0);
                    in_tid = 8'($urandom);
                end else begin
                    in_tvalid = 1'b0;
                end
            end
        end
        reset = 1'b0;
        in_tvalid = 1'b0;
        out_tready = 1'b1;
        wait_cycles(12);
        check("drain_model_empty", model_q.size(), 0);
        check("drain_out_tvalid", out_tvalid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_byte_serializer.md
Name: axis_byte_serializer

Overview:
Downstream stage of the registered stream FIFO. It consumes multi-byte AXI-stream beats (tdata/tkeep/tlast/tid) and emits one byte per cycle toward the ESDI NRZ serializer. It packs out the kept bytes in little-endian order and marks the final byte of each frame with tlast. Per-frame byte and frame counters are kept for status.

Parameters:
WIDTH_IN_BYTES, 4, input beat width in bytes (must be >= 2)
TID_WIDTH, 8, width of tid carried alongside each beat/byte
COUNT_WIDTH, 16, width of the per-frame byte counter

Ports:
clk  in  1  single clock
reset  in  1  synchronous, active-high reset
in_tvalid  in  1  input beat valid
in_tready  out  1  input beat accepted when high with in_tvalid
in_tdata  in  8*WIDTH_IN_BYTES  beat data, byte i = bits [8i+7:8i]
in_tkeep  in  WIDTH_IN_BYTES  byte i valid when bit i set
in_tlast  in  1  beat ends frame
in_tid  in  TID_WIDTH  stream id
out_tvalid  out  1  byte valid (registered)
out_tready  in  1  downstream accepts byte
out_tdata  out  8  byte (registered)
out_tlast  out  1  last byte of frame (registered)
out_tid  out  TID_WIDTH  id of beat this byte came from (registered)
byte_count  out  COUNT_WIDTH  bytes handshaken so far in current frame
frame_count  out  16  frames completed, wraps
null_last  out  1  sticky: a tlast beat arrived with tkeep == 0

Behaviour:
- Reset (sync, active-high, dominates everything): out_tvalid=0, out_tdata=0, out_tlast=0, out_tid=0, hold mask=0, byte_count=0, frame_count=0, null_last=0. A partially emitted beat is discarded; no tlast is issued for it.
- advance = !out_tvalid || out_tready.
- Internal hold state: hold_data, hold_mask (bytes still to emit), hold_last, hold_tid.
- in_tready = advance && (hold_mask has at most one bit set). This path is combinational from out_tready by design.
- Each advance cycle:
  - if hold_mask != 0: emit the byte at the lowest set bit of hold_mask and clear that bit.
  - else if an input beat is accepted with in_tkeep != 0: emit its lowest kept byte directly, and load the remaining kept bits into hold_mask along with data, last and tid.
  - if hold_mask was one-hot and an input is accepted in the same cycle: emit the held byte, load the new beat with its full kept mask. No bubble.
  - if nothing is emittable: out_tvalid <= 0.
- out_tlast = beat's tlast AND the emitted byte is the last kept byte of that beat.
- Latency: a beat accepted at edge k gives its first byte valid after edge k. Sustained throughput is 1 byte/cycle.
- Beat with in_tkeep == 0: accepted and dropped, no byte emitted.
  - If it also has in_tlast: set null_last, frame_count += 1, byte_count <= 0.
- Interior zero bytes (e.g. keep=4'b1010): skipped with no idle cycle, next byte emitted next advance.
- Output held stable while out_tvalid && !out_tready.
- byte_count: +1 on each out handshake, saturating at all-ones. On a handshake with out_tlast it becomes 0 and frame_count increments (wrap at 2^16).

Decomposition:
- Shared package: the AXI-stream byte-lane constants (lane width 8) and the lowest-set-bit / one-hot helper functions.
- One natural sub-module: axis_lane_picker. It is combinational: given a mask, it returns the lowest set index, the mask with that bit cleared, and an is_last flag. The serializer state and counters stay in the top block.

Test Plan:
- Beat 0x44332211 keep=1111 last=1 tid=5, out_tready=1: bytes 11,22,33,44 on 4 consecutive cycles, tlast only on 44, tid=5. byte_count returns to 0, frame_count=1.
- Back-to-back beats 0x04030201/1111/0 and 0x08070605/0011/1, ready=1: bytes 01..06 with no gap, tlast on 06. in_tready is low for exactly 3 cycles per 4-byte beat.
- keep=1010 data 0xDDCCBBAA last=1: outputs BB then DD(tlast), 2 cycles.
- keep=0000 last=1: no output byte, null_last=1 (sticky), frame_count +1.
- out_tready toggling 1,0,0,1 mid-beat: out_tdata/out_tlast/out_tid held stable while stalled, no byte lost or duplicated.
- reset asserted after 2 of 4 bytes emitted: next cycle out_tvalid=0 and counters are 0. The following beat emits from its byte 0.
